flit_packer: RTL and testbench

Downstream consumer of the 64-slot byte-wide virtual-channel FIFO in each NoC input port. Pops a header byte and its payload bytes from the FIFO, then packs the payload into 32-bit flits with destination, byte-keep and last markers. Flits go to the router core over a valid/ready handshake. One packer serves one virtual channel.

---
 rtl/flit_packer.sv | 137 +++++++++++++
 tb/tb_flit_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_packer.sv
// rtl/flit_packer.sv - pops header+payload bytes from a VC FIFO and packs them into 32-bit flits
module flit_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [31:0] flit_data,
    output logic [3:0]  flit_dest,
    output logic [3:0]  flit_keep,
    output logic        flit_last,
    output logic        len_err,
    output logic [7:0]  pkt_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dest_q;
    logic [3:0]  rem_q;
    logic [2:0]  lane_cnt_q;
    logic [31:0] data_q;
    logic [3:0]  keep_q;
    logic        last_q;
    logic        valid_q;
    logic        len_err_q;
    logic [7:0]  pkt_count_q;

    logic [3:0]  rem_dec;
    logic [2:0]  lane_inc;
    logic        hdr_pop;
    logic        byte_pop;
    logic        flit_done;

    assign rem_dec   = rem_q - 4'd1;
    assign lane_inc  = lane_cnt_q + 3'd1;
    assign hdr_pop   = (state_q == IDLE) && !fifo_empty;
    assign byte_pop  = (state_q == GATHER) && !fifo_empty;
    assign flit_done = (state_q == SEND) && flit_ready;

    // Gated by reset so the pop request is already low while reset is held.
    assign fifo_rd_en = !reset && (hdr_pop || byte_pop);

    assign flit_valid = valid_q;
    assign flit_data  = data_q;
    assign flit_dest  = dest_q;
    assign flit_keep  = keep_q;
    assign flit_last  = last_q;
    assign len_err    = len_err_q;
    assign pkt_count  = pkt_count_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-length header is dropped without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (fifo_data[3:0] != 4'd0)) begin
                    state_d = GATHER;
                end
            end
            GATHER: begin
                if (!fifo_empty && ((lane_inc == 3'd4) || (rem_dec == 4'd0))) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (flit_ready) begin
                    state_d = last_q ? IDLE : GATHER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: header latch, lane fill, flit hand-off and packet counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q      <= 4'd0;
            rem_q       <= 4'd0;
            lane_cnt_q  <= 3'd0;
            data_q      <= 32'd0;
            keep_q      <= 4'd0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            len_err_q   <= 1'b0;
            pkt_count_q <= 8'd0;
        end else begin
            valid_q   <= (state_d == SEND);
            len_err_q <= hdr_pop && (fifo_data[3:0] == 4'd0);
            if (hdr_pop) begin
                dest_q     <= fifo_data[7:4];
                rem_q      <= fifo_data[3:0];
                lane_cnt_q <= 3'd0;
                data_q     <= 32'd0;
                keep_q     <= 4'd0;
                last_q     <= 1'b0;
            end
            if (byte_pop) begin
                case (lane_cnt_q[1:0])
                    2'd0:    data_q[7:0]   <= fifo_data;
                    2'd1:    data_q[15:8]  <= fifo_data;
                    2'd2:    data_q[23:16] <= fifo_data;
                    default: data_q[31:24] <= fifo_data;
                endcase
                keep_q     <= {keep_q[2:0], 1'b1};
                lane_cnt_q <= lane_inc;
                rem_q      <= rem_dec;
                last_q     <= (rem_dec == 4'd0);
            end
            if (flit_done) begin
                if (last_q) begin
                    pkt_count_q <= pkt_count_q + 8'd1;
                end else begin
                    data_q     <= 32'd0;
                    keep_q     <= 4'd0;
                    lane_cnt_q <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_flit_packer.sv
// tb/tb_flit_packer.sv - scoreboard bench for flit_packer with a byte FIFO model
module tb_flit_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'd0;
    logic        fifo_rd_en;
    logic        flit_valid;
    logic        flit_ready = 1'b1;
    logic [31:0] flit_data;
    logic [3:0]  flit_dest;
    logic [3:0]  flit_keep;
    logic        flit_last;
    logic        len_err;
    logic [7:0]  pkt_count;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dest;
        logic [3:0]  keep;
        logic        last;
    } flit_t;

    flit_t      exp_q[$];
    logic [7:0] fifo_q[$];
    flit_t      held_f;
    logic       held = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int len_err_seen = 0;
    int flits_seen = 0;
    int first_valid_cyc = -1;
    int stall_len = 0;
    int wait_cnt = 0;
    int start = 0;
    int base_flits = 0;

    flit_packer dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .flit_dest  (flit_dest),
        .flit_keep  (flit_keep),
        .flit_last  (flit_last),
        .len_err    (len_err),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 8'd0 : fifo_q[0];
    endtask

    // Pushes the header and the first nnow payload bytes; builds expected flits for the whole packet.
    task automatic push_packet(input logic [7:0] hdr, input logic [119:0] bytes, input int nnow);
        int    len;
        flit_t f;
        len = int'(hdr[3:0]);
        fifo_q.push_back(hdr);
        for (int i = 0; i < nnow && i < len; i++) fifo_q.push_back(bytes[8*i +: 8]);
        for (int fi = 0; fi * 4 < len; fi++) begin
            f.data = 32'd0;
            f.keep = 4'd0;
            f.dest = hdr[7:4];
            for (int l = 0; l < 4 && (fi * 4 + l) < len; l++) begin
                f.data[8*l +: 8] = bytes[8*(fi*4+l) +: 8];
                f.keep[l] = 1'b1;
            end
            f.last = ((fi * 4 + 4) >= len);
            exp_q.push_back(f);
        end
        refresh_fifo();
    endtask

    // One clock: sample at negedge, model FIFO pops and downstream ready after the posedge.
    task automatic tick();
        logic  rd;
        flit_t e;
        @(negedge clk);
        rd = fifo_rd_en;
        if (fifo_empty) check("rd_en_when_empty", {31'd0, fifo_rd_en}, 32'd0);
        if (flit_valid) check("rd_en_in_send", {31'd0, fifo_rd_en}, 32'd0);
        if (len_err === 1'b1) len_err_seen++;
        if (held) begin
            check("hold_valid", {31'd0, flit_valid}, 32'd1);
            check("hold_data", flit_data, held_f.data);
            check("hold_dest", {28'd0, flit_dest}, {28'd0, held_f.dest});
            check("hold_keep", {28'd0, flit_keep}, {28'd0, held_f.keep});
            check("hold_last", {31'd0, flit_last}, {31'd0, held_f.last});
        end
        if (flit_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (flit_valid === 1'b1 && flit_ready) begin
            flits_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_flit", {31'd0, flit_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("flit_data", flit_data, e.data);
                check("flit_dest", {28'd0, flit_dest}, {28'd0, e.dest});
                check("flit_keep", {28'd0, flit_keep}, {28'd0, e.keep});
                check("flit_last", {31'd0, flit_last}, {31'd0, e.last});
            end
            held = 1'b0;
            wait_cnt = 0;
        end else if (flit_valid === 1'b1) begin
            held = 1'b1;
            held_f.data = flit_data;
            held_f.dest = flit_dest;
            held_f.keep = flit_keep;
            held_f.last = flit_last;
        end else begin
            held = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rd === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        refresh_fifo();
        if (flit_valid === 1'b1 && wait_cnt < stall_len) begin
            flit_ready = 1'b0;
            wait_cnt++;
        end else begin
            flit_ready = 1'b1;
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0 || flit_valid === 1'b1) && n < max) begin
            tick();
            n++;
        end
        check("drain_within_budget", {31'd0, (n < max)}, 32'd1);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, flit_valid}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        check({tag, "_len_err"}, {31'd0, len_err}, 32'd0);
        check({tag, "_pkt_count"}, {24'd0, pkt_count}, 32'd0);
        check({tag, "_data"}, flit_data, 32'd0);
        check({tag, "_dest_keep_last"}, {23'd0, flit_dest, flit_keep, flit_last}, 32'd0);
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single short packet: 0x32, AA, BB.
        start = cyc; pops = 0; first_valid_cyc = -1; base_flits = flits_seen;
        push_packet(8'h32, 120'hBBAA, 15);
        drain(50);
        check("short_valid_cycle", first_valid_cyc - start, 32'd3);
        check("short_pops", pops, 32'd3);
        check("short_flits", flits_seen - base_flits, 32'd1);
        check("short_pkt_count", {24'd0, pkt_count}, 32'd1);

        // Multi-flit packet: 0x5A then 01..0A.
        start = cyc; pops = 0; first_valid_cyc = -1; base_flits = flits_seen;
        push_packet(8'h5A, 120'h0A0908070605040302_01, 15);
        drain(100);
        check("multi_valid_cycle", first_valid_cyc - start, 32'd5);
        check("multi_pops", pops, 32'd11);
        check("multi_flits", flits_seen - base_flits, 32'd3);
        check("multi_pkt_count", {24'd0, pkt_count}, 32'd2);

        // Backpressure: 7 stall cycles on each flit.
        stall_len = 7; base_flits = flits_seen;
        push_packet(8'h5A, 120'h0A0908070605040302_01, 15);
        drain(300);
        stall_len = 0;
        check("bp_flits", flits_seen - base_flits, 32'd3);
        check("bp_pkt_count", {24'd0, pkt_count}, 32'd3);

        // Zero length header followed by a normal one.
        len_err_seen = 0; base_flits = flits_seen;
        push_packet(8'h70, 120'h0, 15);
        push_packet(8'h91, 120'h5C, 15);
        drain(50);
        check("zero_len_err_pulses", len_err_seen, 32'd1);
        check("zero_flits", flits_seen - base_flits, 32'd1);
        check("zero_pkt_count", {24'd0, pkt_count}, 32'd4);

        // Starvation mid-payload.
        pops = 0; base_flits = flits_seen;
        push_packet(8'h26, 120'h665544332211, 3);
        for (int i = 0; i < 10; i++) tick();
        check("starve_pops", pops, 32'd4);
        check("starve_no_flit", {31'd0, flit_valid}, 32'd0);
        fifo_q.push_back(8'h44);
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        refresh_fifo();
        drain(100);
        check("starve_flits", flits_seen - base_flits, 32'd2);
        check("starve_pkt_count", {24'd0, pkt_count}, 32'd5);

        // Reset mid-GATHER clears everything asynchronously.
        push_packet(8'h5A, 120'h0A0908070605040302_01, 15);
        tick();
        tick();
        tick();
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        refresh_fifo();
        #1;
        check_all_zero("async_reset");
        tick();
        held = 1'b0;
        wait_cnt = 0;
        reset = 1'b0;
        tick();

        // Counter wrap: 256 one-byte packets starting from IDLE.
        base_flits = flits_seen;
        for (int i = 0; i < 255; i++) push_packet(8'hC1, {112'd0, 8'(i)}, 15);
        drain(2000);
        check("wrap_pkt_count_255", {24'd0, pkt_count}, 32'd255);
        push_packet(8'hC1, 120'hEE, 15);
        drain(50);
        check("wrap_pkt_count_0", {24'd0, pkt_count}, 32'd0);
        check("wrap_flits", flits_seen - base_flits, 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
